// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at issue, held as pending, and committed when the counter expires.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [2:0]       mdop,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_phi;
   logic [WIDTH-1:0] r_plo;
   logic             r_pwe;
   logic             r_busy;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [2*WIDTH-1:0] w_smul;
   logic [2*WIDTH-1:0] w_umul;
   logic [WIDTH-1:0]   w_amag;
   logic [WIDTH-1:0]   w_bmag;
   logic [WIDTH-1:0]   w_bsafe;
   logic [WIDTH-1:0]   w_bmsafe;
   logic [WIDTH-1:0]   w_uq;
   logic [WIDTH-1:0]   w_ur;
   logic [WIDTH-1:0]   w_smq;
   logic [WIDTH-1:0]   w_smr;
   logic [WIDTH-1:0]   w_sq;
   logic [WIDTH-1:0]   w_sr;
   logic               w_bzero;
   logic               w_go;

   assign w_go    = start && !flush && (r_state == S_IDLE);
   assign w_bzero = (b == '0);

   // Low 2W bits of a sign-extended product equal the signed product.
   assign w_smul = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign w_umul = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Signed divide via magnitudes; MIN / -1 falls out as MIN rem 0.
   assign w_amag   = a[WIDTH-1] ? -a : a;
   assign w_bmag   = b[WIDTH-1] ? -b : b;
   assign w_bsafe  = w_bzero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
   assign w_bmsafe = w_bzero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_bmag;
   assign w_uq     = a / w_bsafe;
   assign w_ur     = a % w_bsafe;
   assign w_smq    = w_amag / w_bmsafe;
   assign w_smr    = w_amag % w_bmsafe;
   assign w_sq     = (a[WIDTH-1] ^ b[WIDTH-1]) ? -w_smq : w_smq;
   assign w_sr     = a[WIDTH-1] ? -w_smr : w_smr;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_phi   <= '0;
         r_plo   <= '0;
         r_pwe   <= 1'b0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (r_state == S_BUSY) begin
         if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_pwe   <= 1'b0;
            if (r_pwe) begin
               r_hi <= r_phi;
               r_lo <= r_plo;
            end
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end else if (w_go) begin
         unique case (mdop)
            3'd0: begin
               {r_phi, r_plo} <= w_smul;
               r_pwe   <= 1'b1;
               r_cnt   <= CW'(MULT_CYCLES);
               r_busy  <= 1'b1;
               r_state <= S_BUSY;
            end
            3'd1: begin
               {r_phi, r_plo} <= w_umul;
               r_pwe   <= 1'b1;
               r_cnt   <= CW'(MULT_CYCLES);
               r_busy  <= 1'b1;
               r_state <= S_BUSY;
            end
            3'd2: begin
               r_phi   <= w_sr;
               r_plo   <= w_sq;
               r_pwe   <= !w_bzero;
               r_cnt   <= CW'(DIV_CYCLES);
               r_busy  <= 1'b1;
               r_state <= S_BUSY;
            end
            3'd3: begin
               r_phi   <= w_ur;
               r_plo   <= w_uq;
               r_pwe   <= !w_bzero;
               r_cnt   <= CW'(DIV_CYCLES);
               r_busy  <= 1'b1;
               r_state <= S_BUSY;
            end
            3'd4:    r_hi <= a;
            3'd5:    r_lo <= a;
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: default 32-bit instance plus a 16-bit short-latency instance.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        clr, start, flush;
   logic [2:0]  mdop;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;

   logic        s_start;
   logic [2:0]  s_mdop;
   logic [15:0] s_a, s_b;
   logic        s_busy;
   logic [15:0] s_hi, s_lo;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   md_unit u_dut (
      .clk(clk), .clr(clr), .start(start), .mdop(mdop), .flush(flush),
      .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
   );

   md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_small (
      .clk(clk), .clr(clr), .start(s_start), .mdop(s_mdop), .flush(flush),
      .a(s_a), .b(s_b), .busy(s_busy), .hi(s_hi), .lo(s_lo)
   );

   task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      start = 1'b1; mdop = op; a = va; b = vb;
      @(negedge clk);
      start = 1'b0; a = 32'hA5A5_5A5A; b = 32'h5A5A_A5A5;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      clr = 1'b1; start = 1'b0; flush = 1'b0; mdop = 3'd7; a = '0; b = '0;
      s_start = 1'b0; s_mdop = 3'd7; s_a = '0; s_b = '0;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_bad++;
         $display("FAIL reset: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
      repeat (20) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_bad++;
         $display("FAIL idle_hold: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
   endtask

   task automatic test_mult;
      int n;
      issue(3'd0, 32'hFFFF_FFFF, 32'd2);
      wait_done(n);
      n_cmp++;
      if (n !== 5) begin
         n_bad++;
         $display("FAIL mult_busy: got %0d cycles, want 5", n);
      end
      n_cmp++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
         n_bad++;
         $display("FAIL mult: hi=%h lo=%h, want ffffffff/fffffffe", hi, lo);
      end
      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_done(n);
      n_cmp++;
      if (n !== 5 || hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
         n_bad++;
         $display("FAIL multu: n=%0d hi=%h lo=%h, want 5/00000001/fffffffe", n, hi, lo);
      end
   endtask

   task automatic test_div;
      int n;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      n_cmp++;
      if (n !== 10) begin
         n_bad++;
         $display("FAIL div_busy: got %0d cycles, want 10", n);
      end
      n_cmp++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         n_bad++;
         $display("FAIL div_signed: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
      end
      issue(3'd4, 32'h11, 32'h0);
      issue(3'd5, 32'h22, 32'h0);
      issue(3'd3, 32'd7, 32'd0);
      wait_done(n);
      n_cmp++;
      if (n !== 10 || hi !== 32'h11 || lo !== 32'h22) begin
         n_bad++;
         $display("FAIL divu_zero: n=%0d hi=%h lo=%h, want 10/11/22", n, hi, lo);
      end
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n);
      n_cmp++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         n_bad++;
         $display("FAIL div_overflow: hi=%h lo=%h, want 0/80000000", hi, lo);
      end
   endtask

   task automatic test_flush;
      int n;
      flush = 1'b1;
      issue(3'd0, 32'd3, 32'd4);
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
         n_bad++;
         $display("FAIL flush_start: busy=%b hi=%h lo=%h, want 0/0/80000000", busy, hi, lo);
      end
      issue(3'd0, 32'd3, 32'd4);
      flush = 1'b1; start = 1'b1; mdop = 3'd5; a = 32'd9;
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_busy: busy=%b, want 1", busy);
      end
      wait_done(n);
      n_cmp++;
      if (n !== 4 || hi !== 32'h0 || lo !== 32'd12) begin
         n_bad++;
         $display("FAIL back_to_back: n=%0d hi=%h lo=%h, want 4/0/c", n, hi, lo);
      end
   endtask

   task automatic test_mthi_clr;
      issue(3'd4, 32'hDEAD_BEEF, 32'h0);
      n_cmp++;
      if (hi !== 32'hDEAD_BEEF || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL mthi: hi=%h busy=%b, want deadbeef/0", hi, busy);
      end
      issue(3'd3, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_bad++;
         $display("FAIL clr_mid_div: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
      repeat (15) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_bad++;
         $display("FAIL clr_no_late: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
      end
   endtask

   task automatic test_small;
      int n;
      @(negedge clk);
      s_start = 1'b1; s_mdop = 3'd0; s_a = 16'h8000; s_b = 16'h8000;
      @(negedge clk);
      s_start = 1'b0;
      n = 0;
      while (s_busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      n_cmp++;
      if (n !== 1 || s_hi !== 16'h4000 || s_lo !== 16'h0000) begin
         n_bad++;
         $display("FAIL small_mult: n=%0d hi=%h lo=%h, want 1/4000/0000", n, s_hi, s_lo);
      end
      @(negedge clk);
      s_start = 1'b1; s_mdop = 3'd3; s_a = 16'd100; s_b = 16'd7;
      @(negedge clk);
      s_start = 1'b0;
      n = 0;
      while (s_busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      n_cmp++;
      if (n !== 3 || s_hi !== 16'd2 || s_lo !== 16'd14) begin
         n_bad++;
         $display("FAIL small_divu: n=%0d hi=%0d lo=%0d, want 3/2/14", n, s_hi, s_lo);
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_flush;
      test_mthi_clr;
      test_small;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
